// File: rtl/ff.sv
// ----------------------------------------------------------------------------
// ff: D flip-flop with a synchronous active-low clear. It is the storage
// element of the phase/frequency detector, where two instances latch the
// rising edges of the reference clock (UP) and the divided VCO clock (DOWN).
//
// Parameters:
//   WIDTH   - data/output width in bits (>= 1)
//   RST_VAL - value loaded by clear and held at power-up
//
// Ports (positional order is fixed; the detector instantiates positionally):
//   d   - data input, sampled on the rising edge of clk
//   cd  - synchronous active-low clear (0 = load RST_VAL at the next edge)
//   clk - sampling clock, rising-edge active
//   q   - registered output, no combinational path from any input
// ----------------------------------------------------------------------------
module ff #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             cd,
    input  logic             clk,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("ff: WIDTH must be at least 1");
    end

    // Power-up value keeps the detector's U && D -> cd feedback loop free of
    // X before the first clock edge arrives.
    logic [WIDTH-1:0] q_r = RST_VAL;

    always_ff @(posedge clk) begin
        if (!cd) begin
            q_r <= RST_VAL;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

    // An unknown clear at a sampling edge would corrupt the detector state.
    a_cd_known : assert property (@(posedge clk) !$isunknown(cd))
        else $error("ff: cd is X/Z at a rising edge of clk");

endmodule

// File: tb/tb_ff.sv
`timescale 1ns/1ps
module tb_ff;

    typedef struct {
        logic       cd;
        logic [3:0] d;
        logic [3:0] exp_q;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // single-bit instance, hand-clocked
    logic       clk1 = 1'b0;
    logic       cd1  = 1'b1;
    logic [0:0] d1   = 1'b1;
    logic [0:0] q1;

    // 4-bit instance with a non-zero clear value
    logic       clk4 = 1'b0;
    logic       cd4  = 1'b1;
    logic [3:0] d4   = 4'h0;
    logic [3:0] q4;

    // detector pairing
    logic f_ref = 1'b0;
    logic f_div = 1'b0;
    logic rst   = 1'b0;
    logic u_q, d_q, cd_pd;
    logic mu, md;
    assign cd_pd = rst && !(u_q && d_q);

    ff #(.WIDTH(1)) u_ff1 (.d(d1), .cd(cd1), .clk(clk1), .q(q1));
    ff #(.WIDTH(4), .RST_VAL(4'hA)) u_ff4 (.d(d4), .cd(cd4), .clk(clk4), .q(q4));
    ff #(.WIDTH(1)) u_up (.d(1'b1), .cd(cd_pd), .clk(f_ref), .q(u_q));
    ff #(.WIDTH(1)) u_dn (.d(1'b1), .cd(cd_pd), .clk(f_div), .q(d_q));

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One 20 ns detector period; each latch follows the rule q <= clear ? 0 : 1
    // with the clear formed from the latch values just before its own edge.
    task automatic pd_cycle(input int ref_dly, input int div_dly, input string tag);
        fork
            begin
                #(ref_dly);
                f_ref = 1'b1;
                mu = (rst && !(mu && md)) ? 1'b1 : 1'b0;
                #1;
                check({tag, " U@ref"}, {3'b0, u_q}, {3'b0, mu});
                check({tag, " D@ref"}, {3'b0, d_q}, {3'b0, md});
                #9 f_ref = 1'b0;
            end
            begin
                #(div_dly);
                f_div = 1'b1;
                md = (rst && !(mu && md)) ? 1'b1 : 1'b0;
                #1;
                check({tag, " U@div"}, {3'b0, u_q}, {3'b0, mu});
                check({tag, " D@div"}, {3'b0, d_q}, {3'b0, md});
                #9 f_div = 1'b0;
            end
        join
        #(10 - ((ref_dly > div_dly) ? ref_dly : div_dly));
    endtask

    task automatic pd_run(input int ref_dly, input int div_dly, input string tag);
        rst = 1'b0;
        pd_cycle(ref_dly, div_dly, {tag, " rst"});
        rst = 1'b1;
        for (int c = 0; c < 4; c++) pd_cycle(ref_dly, div_dly, tag);
    endtask

    vec_t vecs[9];
    logic [3:0] exp4;

    initial begin
        mu = 1'b0;
        md = 1'b0;

        // ---------------- power-up ----------------
        #1;
        check("pwrup q1", {3'b0, q1}, 4'h0);
        check("pwrup q4", q4, 4'hA);
        check("pwrup U", {3'b0, u_q}, 4'h0);
        check("pwrup D", {3'b0, d_q}, 4'h0);
        #4;
        check("pwrup q1 hold", {3'b0, q1}, 4'h0);

        // ---------------- capture and falling-edge immunity ----------------
        clk1 = 1'b1; #1;                       // t=6
        check("capture 1", {3'b0, q1}, 4'h1);
        d1 = 1'b0;
        #9 clk1 = 1'b0; #1;                    // falling edge with d=0
        check("fall no effect", {3'b0, q1}, 4'h1);
        #9 clk1 = 1'b1; #1;
        check("capture 0", {3'b0, q1}, 4'h0);
        #9 clk1 = 1'b0;

        // ---------------- synchronous clear ----------------
        d1 = 1'b1;
        #10 clk1 = 1'b1; #1;
        check("reload 1", {3'b0, q1}, 4'h1);
        #9 clk1 = 1'b0;
        cd1 = 1'b0;
        #3;
        check("clr no edge", {3'b0, q1}, 4'h1);
        #7 clk1 = 1'b1; #1;
        check("clr at edge", {3'b0, q1}, 4'h0);
        cd1 = 1'b1;
        #9 clk1 = 1'b0;
        #10 clk1 = 1'b1; #1;
        check("clr release", {3'b0, q1}, 4'h1);

        // ---------------- clear pulse between edges ----------------
        #9 clk1 = 1'b0;
        #4 cd1 = 1'b0;
        #1;
        check("pulse mid", {3'b0, q1}, 4'h1);
        #1 cd1 = 1'b1;
        #4 clk1 = 1'b1; #1;
        check("pulse ignored", {3'b0, q1}, 4'h1);
        #9 clk1 = 1'b0;

        // ---------------- WIDTH=4 vector table ----------------
        vecs[0] = '{1'b1, 4'h5, 4'h5};
        vecs[1] = '{1'b0, 4'h5, 4'hA};
        vecs[2] = '{1'b1, 4'h3, 4'h3};
        vecs[3] = '{1'b1, 4'hF, 4'hF};
        vecs[4] = '{1'b0, 4'h0, 4'hA};
        vecs[5] = '{1'b0, 4'hF, 4'hA};
        vecs[6] = '{1'b1, 4'h0, 4'h0};
        vecs[7] = '{1'b1, 4'hA, 4'hA};
        vecs[8] = '{1'b0, 4'h5, 4'hA};
        for (int i = 0; i < 9; i++) begin
            cd4 = vecs[i].cd;
            d4  = vecs[i].d;
            #5 clk4 = 1'b1; #1;
            check($sformatf("vec%0d", i), q4, vecs[i].exp_q);
            #4 clk4 = 1'b0;
        end

        // ---------------- randomized WIDTH=4 ----------------
        exp4 = q4;
        for (int i = 0; i < 150; i++) begin
            logic       c;
            logic [3:0] dv;
            c  = ($urandom_range(3) != 0);
            dv = 4'($urandom);
            cd4 = c;
            d4  = dv;
            #5 clk4 = 1'b1;
            exp4 = c ? dv : 4'hA;
            #1;
            check("rand edge", q4, exp4);
            #4 clk4 = 1'b0;
            if ($urandom_range(1) == 1) begin
                // input churn with no rising edge must not move q
                cd4 = ~cd4;
                d4  = 4'($urandom);
                #1;
                check("rand hold", q4, exp4);
            end
        end
        cd4 = 1'b1;

        // ---------------- detector pairing ----------------
        // U leads by 2 ns: U rises, D 2 ns later, U clears at its next edge;
        // D then recaptures because U has already cleared by its next edge.
        pd_run(0, 2, "pd ref-lead");
        // Mirror image: the divided clock leads.
        pd_run(2, 0, "pd div-lead");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
